// File: rtl/rrf_alloc.sv
// Rename register file tag allocator: a circular buffer of RRF_ENT_NUM tags
// handed out at tail by dispatch, retired at head by commit, rewound by flush.
module rrf_alloc #(
  parameter int RRF_ENT_NUM = 64,
  parameter int RRF_ENT_SEL = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_dp_req_1,
  input  logic                   i_dp_req_2,
  input  logic                   i_stall,
  output logic                   o_alloc_rdy,
  output logic [RRF_ENT_SEL-1:0] o_dp_rrftag_1,
  output logic [RRF_ENT_SEL-1:0] o_dp_rrftag_2,
  input  logic [1:0]             i_com_num,
  output logic [RRF_ENT_SEL-1:0] o_com_ptr_1,
  output logic [RRF_ENT_SEL-1:0] o_com_ptr_2,
  input  logic                   i_flush,
  input  logic [RRF_ENT_SEL-1:0] i_flush_tail,
  output logic [RRF_ENT_SEL:0]   o_freenum,
  output logic                   o_full
);

  localparam int FW = RRF_ENT_SEL + 1;
  localparam logic [RRF_ENT_SEL:0] FREE_MAX = FW'(RRF_ENT_NUM);

  logic [RRF_ENT_SEL-1:0] tail;
  logic [RRF_ENT_SEL-1:0] head;
  logic [RRF_ENT_SEL-1:0] head_next;
  logic [RRF_ENT_SEL-1:0] flush_dist;
  logic [RRF_ENT_SEL:0]   freenum;
  logic [RRF_ENT_SEL:0]   reqnum;
  logic [RRF_ENT_SEL:0]   allocnum;
  logic                   fire;

  // Handshake: the dispatch request (i_dp_req_1/2) is the valid, o_alloc_rdy is
  // the ready; tags transfer only when valid && ready && !i_stall, and a
  // request that cannot be fully served is refused as a whole.
  assign reqnum      = FW'(i_dp_req_1) + FW'(i_dp_req_2);
  assign o_alloc_rdy = (freenum >= reqnum) && !i_flush;
  assign fire        = (reqnum != '0) && o_alloc_rdy && !i_stall;
  assign allocnum    = fire ? reqnum : '0;

  // Slot 2 takes the tag after slot 1 only when slot 1 is actually asking.
  assign o_dp_rrftag_1 = tail;
  assign o_dp_rrftag_2 = tail + RRF_ENT_SEL'(i_dp_req_1);

  assign o_com_ptr_1 = head;
  assign o_com_ptr_2 = head + RRF_ENT_SEL'(1);

  assign head_next  = head + RRF_ENT_SEL'(i_com_num);
  // Distance wraps modulo the buffer size, so tail == head_next reads as empty.
  assign flush_dist = i_flush_tail - head_next;

  assign o_freenum = freenum;
  assign o_full    = (freenum == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tail    <= '0;
      head    <= '0;
      freenum <= FREE_MAX;
    end else begin
      head <= head_next;
      if (i_flush) begin
        tail    <= i_flush_tail;
        freenum <= FREE_MAX - {1'b0, flush_dist};
      end else begin
        tail    <= tail + allocnum[RRF_ENT_SEL-1:0];
        freenum <= freenum - allocnum + FW'(i_com_num);
      end
    end
  end

  // Retiring more entries than are live leaves the pointers meaningless.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (FW'(i_com_num) <= (FREE_MAX - freenum))
        else $error("rrf_alloc: i_com_num %0d exceeds live entries %0d",
                    i_com_num, FREE_MAX - freenum);
    end
  end

endmodule

// File: tb/tb_rrf_alloc.sv
// Bench for rrf_alloc: directed scenarios plus a randomized run, all checked
// against an integer-arithmetic model of the tag buffer.
module tb_rrf_alloc;

  localparam int N = 64;
  localparam int S = 6;

  logic         clk;
  logic         rst_n;
  logic         req_1, req_2, stall, flush;
  logic [1:0]   com_num;
  logic [S-1:0] flush_tail;
  logic         alloc_rdy, full;
  logic [S-1:0] tag_1, tag_2, com_ptr_1, com_ptr_2;
  logic [S:0]   freenum;

  int total = 0;
  int bad   = 0;

  // Reference model state: plain integers, pointers kept in 0..N-1.
  int mdl_head, mdl_tail, mdl_free;
  logic [S-1:0] exp_q[$];

  rrf_alloc #(.RRF_ENT_NUM(N), .RRF_ENT_SEL(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_dp_req_1(req_1), .i_dp_req_2(req_2), .i_stall(stall),
    .o_alloc_rdy(alloc_rdy), .o_dp_rrftag_1(tag_1), .o_dp_rrftag_2(tag_2),
    .i_com_num(com_num), .o_com_ptr_1(com_ptr_1), .o_com_ptr_2(com_ptr_2),
    .i_flush(flush), .i_flush_tail(flush_tail),
    .o_freenum(freenum), .o_full(full)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  task automatic mdl_update();
    int reqn, hn;
    bit fire;
    if (!rst_n) begin
      mdl_head = 0; mdl_tail = 0; mdl_free = N;
    end else begin
      reqn = int'(req_1) + int'(req_2);
      fire = (reqn > 0) && (mdl_free >= reqn) && !flush && !stall;
      hn   = (mdl_head + int'(com_num)) % N;
      if (flush) begin
        mdl_tail = int'(flush_tail);
        mdl_free = N - ((int'(flush_tail) - hn + N) % N);
      end else begin
        if (fire) mdl_tail = (mdl_tail + reqn) % N;
        mdl_free = mdl_free - (fire ? reqn : 0) + int'(com_num);
      end
      mdl_head = hn;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit r1, input bit r2, input bit st, input int cn,
                       input bit fl, input int ft);
    req_1 = r1; req_2 = r2; stall = st; com_num = 2'(cn);
    flush = fl; flush_tail = S'(ft);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_update();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    total++; if (tag_1 !== 6'd0) begin bad++; $display("FAIL reset_tag1: got %0d expected 0", tag_1); end
    total++; if (com_ptr_1 !== 6'd0) begin bad++; $display("FAIL reset_ptr1: got %0d expected 0", com_ptr_1); end
    total++; if (com_ptr_2 !== 6'd1) begin bad++; $display("FAIL reset_ptr2: got %0d expected 1", com_ptr_2); end
    total++; if (freenum !== 7'd64) begin bad++; $display("FAIL reset_freenum: got %0d expected 64", freenum); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0d expected 0", full); end
    total++; if (alloc_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %0d expected 1", alloc_rdy); end
  endtask

  task automatic test_fill();
    logic [S-1:0] e1, e2;
    exp_q.delete();
    for (int t = 0; t < N; t++) exp_q.push_back(S'(t));
    for (int i = 0; i < 32; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      total++; if (tag_1 !== e1) begin bad++; $display("FAIL fill_tag1: got %0d expected %0d", tag_1, e1); end
      total++; if (tag_2 !== e2) begin bad++; $display("FAIL fill_tag2: got %0d expected %0d", tag_2, e2); end
      tick();
    end
    drive(1, 1, 0, 0, 0, 0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %0d expected 1", full); end
    total++; if (freenum !== 7'd0) begin bad++; $display("FAIL fill_freenum: got %0d expected 0", freenum); end
    total++; if (alloc_rdy !== 1'b0) begin bad++; $display("FAIL fill_rdy: got %0d expected 0", alloc_rdy); end
  endtask

  // Starts full with head = tail = 0.
  task automatic test_freenum_one();
    drive(0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0);
    total++; if (alloc_rdy !== 1'b0) begin bad++; $display("FAIL one_rdy_both: got %0d expected 0", alloc_rdy); end
    tick();
    total++; if (tag_1 !== 6'd0) begin bad++; $display("FAIL one_tail_held: got %0d expected 0", tag_1); end
    total++; if (freenum !== 7'd1) begin bad++; $display("FAIL one_free_held: got %0d expected 1", freenum); end
    drive(0, 1, 0, 0, 0, 0);
    total++; if (tag_2 !== 6'd0) begin bad++; $display("FAIL one_slot2_tag: got %0d expected 0", tag_2); end
    total++; if (alloc_rdy !== 1'b1) begin bad++; $display("FAIL one_slot2_rdy: got %0d expected 1", alloc_rdy); end
    tick();
    total++; if (freenum !== 7'd0) begin bad++; $display("FAIL one_slot2_free: got %0d expected 0", freenum); end
    total++; if (tag_1 !== 6'd1) begin bad++; $display("FAIL one_slot2_tail: got %0d expected 1", tag_1); end
  endtask

  // Starts full with head = 1, tail = 1.
  task automatic test_full_commit();
    drive(1, 1, 0, 2, 0, 0);
    total++; if (alloc_rdy !== 1'b0) begin bad++; $display("FAIL fc_rdy_same: got %0d expected 0", alloc_rdy); end
    tick();
    total++; if (freenum !== 7'd2) begin bad++; $display("FAIL fc_free_after_com: got %0d expected 2", freenum); end
    total++; if (com_ptr_1 !== 6'd3) begin bad++; $display("FAIL fc_head: got %0d expected 3", com_ptr_1); end
    drive(1, 1, 0, 0, 0, 0);
    total++; if (alloc_rdy !== 1'b1) begin bad++; $display("FAIL fc_rdy_next: got %0d expected 1", alloc_rdy); end
    total++; if (tag_1 !== 6'd1 || tag_2 !== 6'd2) begin bad++; $display("FAIL fc_tags: got %0d,%0d expected 1,2", tag_1, tag_2); end
    tick();
    total++; if (freenum !== 7'd0) begin bad++; $display("FAIL fc_free_after_grant: got %0d expected 0", freenum); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fc_full: got %0d expected 1", full); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0; drive(0, 0, 0, 0, 0, 0); tick(); rst_n = 1'b1;
    for (int i = 0; i < 31; i++) begin drive(1, 1, 0, 0, 0, 0); tick(); end
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 2, 0, 0); tick();
    total++; if (tag_1 !== 6'd63) begin bad++; $display("FAIL wrap_tail63: got %0d expected 63", tag_1); end
    total++; if (freenum !== 7'd3) begin bad++; $display("FAIL wrap_free: got %0d expected 3", freenum); end
    drive(1, 1, 0, 0, 0, 0);
    total++; if (tag_1 !== 6'd63 || tag_2 !== 6'd0) begin bad++; $display("FAIL wrap_tags: got %0d,%0d expected 63,0", tag_1, tag_2); end
    tick();
    total++; if (tag_1 !== 6'd1) begin bad++; $display("FAIL wrap_tail1: got %0d expected 1", tag_1); end
  endtask

  task automatic test_flush();
    rst_n = 1'b0; drive(0, 0, 0, 0, 0, 0); tick(); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin drive(1, 1, 0, 0, 0, 0); tick(); end
    drive(0, 0, 0, 2, 0, 0); tick();
    drive(0, 0, 0, 2, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    total++; if (com_ptr_1 !== 6'd5 || tag_1 !== 6'd20) begin bad++; $display("FAIL flush_setup: got head %0d tail %0d expected 5,20", com_ptr_1, tag_1); end
    drive(1, 1, 0, 1, 1, 10);
    total++; if (alloc_rdy !== 1'b0) begin bad++; $display("FAIL flush_rdy: got %0d expected 0", alloc_rdy); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    total++; if (com_ptr_1 !== 6'd6) begin bad++; $display("FAIL flush_head: got %0d expected 6", com_ptr_1); end
    total++; if (tag_1 !== 6'd10) begin bad++; $display("FAIL flush_tail: got %0d expected 10", tag_1); end
    total++; if (freenum !== 7'd60) begin bad++; $display("FAIL flush_free: got %0d expected 60", freenum); end
  endtask

  // Starts with head = 6, tail = 10.
  task automatic test_flush_empty_and_reset();
    drive(0, 0, 0, 0, 1, 6);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    total++; if (freenum !== 7'd64) begin bad++; $display("FAIL fe_free: got %0d expected 64", freenum); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL fe_full: got %0d expected 0", full); end
    for (int i = 0; i < 5; i++) begin drive(1, 1, 0, 0, 0, 0); tick(); end
    total++; if (freenum !== 7'd54) begin bad++; $display("FAIL fe_alloc_free: got %0d expected 54", freenum); end
    rst_n = 1'b0;
    drive(1, 1, 0, 1, 0, 0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    total++; if (tag_1 !== 6'd0 || com_ptr_1 !== 6'd0 || com_ptr_2 !== 6'd1) begin bad++; $display("FAIL midrst_ptrs: got %0d,%0d,%0d expected 0,0,1", tag_1, com_ptr_1, com_ptr_2); end
    total++; if (freenum !== 7'd64) begin bad++; $display("FAIL midrst_free: got %0d expected 64", freenum); end
  endtask

  task automatic test_random();
    int occ, cmax, reqn;
    bit r1, r2, st, fl, rs;
    for (int i = 0; i < 600; i++) begin
      occ  = N - mdl_free;
      cmax = (occ < 2) ? occ : 2;
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 99) != 0);
      rst_n = rs;
      drive(r1, r2, st, $urandom_range(0, cmax), fl, $urandom_range(0, N - 1));
      reqn = int'(r1) + int'(r2);
      total++;
      if (alloc_rdy !== ((mdl_free >= reqn) && !fl) || tag_1 !== S'(mdl_tail) ||
          tag_2 !== S'(mdl_tail + int'(r1)) || com_ptr_1 !== S'(mdl_head) ||
          com_ptr_2 !== S'(mdl_head + 1) || freenum !== (S+1)'(mdl_free) ||
          full !== (mdl_free == 0)) begin
        bad++;
        $display("FAIL rand_cycle%0d: got rdy=%0d t1=%0d t2=%0d h=%0d free=%0d full=%0d expected tail=%0d head=%0d free=%0d",
                 i, alloc_rdy, tag_1, tag_2, com_ptr_1, freenum, full, mdl_tail, mdl_head, mdl_free);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    mdl_head = 0; mdl_tail = 0; mdl_free = N;
    test_reset();
    test_fill();
    test_freenum_one();
    test_full_commit();
    test_wrap();
    test_flush();
    test_flush_empty_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
